// File: rtl/dot_matrix_scan.sv
// Row-multiplexed 16x16 LED matrix driver: serialises one row of a frame snapshot
// into 74HC595-style column registers, latches it, then lights that row for a dwell.
module dot_matrix_scan #(
  parameter int CLK_DIV  = 4,
  parameter int ROW_HOLD = 2000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] i_buffer,
  input  logic         i_blank,
  output logic         o_sclk,
  output logic         o_sdata,
  output logic         o_latch,
  output logic         o_oe_n,
  output logic [3:0]   o_row,
  output logic         o_frame_done
);

  typedef enum logic [1:0] {LOAD, SHIFT, LATCH, HOLD} state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [19:0] HOLD_LAST = 20'(ROW_HOLD - 1);

  state_t         state_q, state_nxt;
  logic [255:0]   frame_q, frame_nxt;
  logic [3:0]     row_q, row_nxt;
  logic [15:0]    div_q, div_nxt;
  logic [3:0]     bit_q, bit_nxt;
  logic [19:0]    hold_q, hold_nxt;
  logic           phase_q, phase_nxt;

  logic           sclk_q, sclk_nxt;
  logic           sdata_q, sdata_nxt;
  logic           latch_q, latch_nxt;
  logic           oe_en_q, oe_en_nxt;
  logic [3:0]     row_out_q, row_out_nxt;
  logic           frame_done_q, frame_done_nxt;

  logic [15:0]    row_bits;

  // Row 0 LOAD reads the incoming buffer directly, since the snapshot lands on the same edge.
  always_comb begin
    if (state_q == LOAD && row_q == 4'd0) row_bits = i_buffer[15:0];
    else                                  row_bits = frame_q[{row_q, 4'b0000} +: 16];
  end

  always_comb begin
    state_nxt   = state_q;
    frame_nxt   = frame_q;
    row_nxt     = row_q;
    div_nxt     = div_q;
    bit_nxt     = bit_q;
    hold_nxt    = hold_q;
    phase_nxt   = phase_q;
    sdata_nxt   = sdata_q;
    row_out_nxt = row_out_q;

    case (state_q)
      LOAD: begin
        if (row_q == 4'd0) frame_nxt = i_buffer;
        state_nxt = SHIFT;
        bit_nxt   = 4'd0;
        div_nxt   = 16'd0;
        phase_nxt = 1'b0;
        sdata_nxt = row_bits[4'd15];
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_nxt = 16'd0;
          if (!phase_q) begin
            phase_nxt = 1'b1;
          end else if (bit_q == 4'd15) begin
            state_nxt   = LATCH;
            phase_nxt   = 1'b0;
            sdata_nxt   = 1'b0;
            row_out_nxt = row_q;
          end else begin
            bit_nxt   = bit_q + 4'd1;
            phase_nxt = 1'b0;
            sdata_nxt = row_bits[~(bit_q + 4'd1)];
          end
        end else begin
          div_nxt = div_q + 16'd1;
        end
      end
      LATCH: begin
        if (div_q == DIV_LAST) begin
          div_nxt   = 16'd0;
          hold_nxt  = 20'd0;
          state_nxt = HOLD;
        end else begin
          div_nxt = div_q + 16'd1;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_nxt  = 20'd0;
          row_nxt   = row_q + 4'd1;
          state_nxt = LOAD;
        end else begin
          hold_nxt = hold_q + 20'd1;
        end
      end
      default: state_nxt = LOAD;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    sclk_nxt       = (state_nxt == SHIFT) && phase_nxt;
    latch_nxt      = (state_nxt == LATCH);
    oe_en_nxt      = (state_nxt == HOLD);
    frame_done_nxt = (state_nxt == HOLD) && (hold_nxt == HOLD_LAST) && (row_q == 4'd15);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      frame_q      <= '0;
      row_q        <= 4'd0;
      div_q        <= 16'd0;
      bit_q        <= 4'd0;
      hold_q       <= 20'd0;
      phase_q      <= 1'b0;
      sclk_q       <= 1'b0;
      sdata_q      <= 1'b0;
      latch_q      <= 1'b0;
      oe_en_q      <= 1'b0;
      row_out_q    <= 4'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      frame_q      <= frame_nxt;
      row_q        <= row_nxt;
      div_q        <= div_nxt;
      bit_q        <= bit_nxt;
      hold_q       <= hold_nxt;
      phase_q      <= phase_nxt;
      sclk_q       <= sclk_nxt;
      sdata_q      <= sdata_nxt;
      latch_q      <= latch_nxt;
      oe_en_q      <= oe_en_nxt;
      row_out_q    <= row_out_nxt;
      frame_done_q <= frame_done_nxt;
    end
  end

  assign o_sclk       = sclk_q;
  assign o_sdata      = sdata_q;
  assign o_latch      = latch_q;
  assign o_oe_n       = ~oe_en_q | i_blank;
  assign o_row        = row_out_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Directed bench for dot_matrix_scan: compares every output each cycle against the
// documented scan timeline, including snapshot, blanking and mid-shift reset behaviour.
module tb_dot_matrix_scan;

  localparam int CLK_DIV  = 2;
  localparam int ROW_HOLD = 10;
  localparam int P        = 77;
  localparam int FRAME    = 1232;
  localparam logic [8:0] RESET_VEC = 9'b0_0_0_1_0000_0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [255:0] i_buffer = '0;
  logic         i_blank = 1'b0;
  logic         o_sclk, o_sdata, o_latch, o_oe_n, o_frame_done;
  logic [3:0]   o_row;

  int tests_run = 0;
  int tests_failed = 0;
  int fd_count;
  int first_fd;
  logic [15:0] shifted;
  logic        sclk_prev;
  logic [15:0] exp_rows [3][16];

  dot_matrix_scan #(.CLK_DIV(CLK_DIV), .ROW_HOLD(ROW_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_buffer     (i_buffer),
    .i_blank      (i_blank),
    .o_sclk       (o_sclk),
    .o_sdata      (o_sdata),
    .o_latch      (o_latch),
    .o_oe_n       (o_oe_n),
    .o_row        (o_row),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [8:0] outputs_now();
    return {o_sclk, o_sdata, o_latch, o_oe_n, o_row, o_frame_done};
  endfunction

  // Expected {sclk, sdata, latch, oe_n, row, frame_done} for cycle cyc after reset release.
  function automatic logic [8:0] expected_outputs(input int cyc, input logic blank);
    int f = cyc / FRAME;
    int r = (cyc % FRAME) / P;
    int p = cyc % P;
    logic [15:0] data;
    logic sclk, sdata, latch, oe_n, fd;
    logic [3:0] row;
    if (f > 2) f = 2;
    data  = exp_rows[f][r];
    sclk  = (p >= 1 && p <= 64) && (((p - 1) / 2) % 2 == 1);
    sdata = (p >= 1 && p <= 64) ? data[15 - (p - 1) / 4] : 1'b0;
    latch = (p == 65 || p == 66);
    oe_n  = (p < 67) || blank;
    if (p >= 65)      row = 4'(r);
    else if (cyc < P) row = 4'd0;
    else              row = 4'((r + 15) % 16);
    fd    = (r == 15) && (p == 76);
    return {sclk, sdata, latch, oe_n, row, fd};
  endfunction

  task automatic applyStimulus(input int run_id, input int cyc);
    if (run_id == 1) begin
      if (cyc == 1000) i_buffer = '1;
      if (cyc == FRAME + 5 * P + 70) i_buffer = '0;
      i_blank = (cyc >= FRAME + 2 * P + 69) && (cyc <= FRAME + 2 * P + 72);
    end else begin
      i_blank = 1'b0;
    end
  endtask

  task automatic runScan(input int run_id, input int last_cyc);
    fd_count  = 0;
    first_fd  = -1;
    sclk_prev = 1'b0;
    for (int cyc = 0; cyc <= last_cyc; cyc++) begin
      if (cyc > 0) @(negedge clk);
      applyStimulus(run_id, cyc);
      #1;
      checkOutput($sformatf("run%0d cyc%0d", run_id, cyc), 32'(outputs_now()), 32'(expected_outputs(cyc, i_blank)));
      if (run_id == 1 && cyc < P && o_sclk && !sclk_prev) shifted = {shifted[14:0], o_sdata};
      sclk_prev = o_sclk;
      if (o_frame_done) begin
        fd_count++;
        if (first_fd < 0) first_fd = cyc;
      end
    end
  endtask

  initial begin
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 16; r++) exp_rows[f][r] = 16'h0000;
    exp_rows[0][0] = 16'hA5C3;
    for (int r = 0; r < 16; r++) exp_rows[1][r] = 16'hFFFF;
    shifted = 16'h0000;

    i_buffer[15:0] = 16'hA5C3;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset hold %0d", i), 32'(outputs_now()), 32'(RESET_VEC));
    end

    @(negedge clk);
    rst_n = 1'b1;
    runScan(1, 2 * FRAME + 3 * P + 30);
    checkOutput("row0 serial bits", 32'(shifted), 32'h0000A5C3);
    checkOutput("run1 frame_done count", 32'(fd_count), 32'd2);
    checkOutput("run1 first frame_done", 32'(first_fd), 32'd1231);

    @(negedge clk);
    rst_n = 1'b0;
    i_buffer = '0;
    i_buffer[15:0]    = 16'h8001;
    i_buffer[127:112] = 16'h0F0F;
    i_buffer[255:240] = 16'hF00D;
    #1;
    checkOutput("mid-shift reset", 32'(outputs_now()), 32'(RESET_VEC));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mid-shift reset hold %0d", i), 32'(outputs_now()), 32'(RESET_VEC));
    end

    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 16; r++) exp_rows[f][r] = 16'h0000;
      exp_rows[f][0]  = 16'h8001;
      exp_rows[f][7]  = 16'h0F0F;
      exp_rows[f][15] = 16'hF00D;
    end
    @(negedge clk);
    rst_n = 1'b1;
    runScan(2, FRAME + 10);
    checkOutput("run2 frame_done count", 32'(fd_count), 32'd1);
    checkOutput("run2 first frame_done", 32'(first_fd), 32'd1231);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
